// File: rtl/jk_excite_driver.sv
// Drives {J,K} excitation codes into a bank of JK cells until the bank holds a
// requested target word, re-driving on mismatch up to MAX_RETRY extra times.
module jk_excite_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [WIDTH-1:0]   tgt,
  input  logic               mode,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [2*WIDTH-1:0] jk,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int            CW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] RETRY_LIMIT = CW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    RESP
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      retry_cnt, retry_nxt;
  logic [WIDTH-1:0]   tgt_r;
  logic               mode_r;
  logic               match_r, match_nxt;
  logic [2*WIDTH-1:0] drive_code;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      retry_cnt <= '0;
      tgt_r     <= '0;
      mode_r    <= 1'b0;
      match_r   <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      match_r   <= match_nxt;
      if (state == IDLE && tgt_valid) begin
        tgt_r  <= tgt;
        mode_r <= mode;
      end
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    drive_code = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_fb[i] != tgt_r[i]) begin
        // When the bit must change, {target, current} is exactly 10 (set) or 01 (reset).
        drive_code[2*i +: 2] = mode_r ? 2'b11 : {tgt_r[i], q_fb[i]};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    match_nxt = match_r;
    unique case (state)
      IDLE: begin
        if (tgt_valid) begin
          state_nxt = DRIVE;
          retry_nxt = '0;
        end
      end
      DRIVE: state_nxt = CHECK;
      CHECK: begin
        if (q_fb == tgt_r) begin
          match_nxt = 1'b1;
          state_nxt = RESP;
        end else if (retry_cnt == RETRY_LIMIT) begin
          match_nxt = 1'b0;
          state_nxt = RESP;
        end else begin
          retry_nxt = retry_cnt + 1'b1;
          state_nxt = DRIVE;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign jk        = (state == DRIVE) ? drive_code : '0;
  assign done      = (state == RESP) &&  match_r;
  assign err       = (state == RESP) && !match_r;

endmodule
